serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing d = x - y - bi, one bit per clock, LSB first, with borrow-in and borrow-out.
- Pairs with the 4-bit ripple adder already in the arithmetic library. It gives the datapath a low-area difference unit with a start/done handshake.
- One full-subtractor cell is reused over WIDTH cycles, and a registered borrow replaces the ripple chain.

Parameters:
- WIDTH, 4: operand and result width in bits. Legal range is 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- x  input  WIDTH  minuend; captured on accepted start.
- y  input  WIDTH  subtrahend; captured on accepted start.
- bi  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when d/bo become valid.
- d  output  WIDTH  difference.
- bo  output  1  borrow-out (1 when x < y + bi, unsigned).

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; busy=0, done=0, d=0, bo=0.
  - internal shift registers, bit counter and borrow flop cleared.
- Reset asserted mid-RUN aborts the operation. No done is produced, and the partial result is discarded (d=0).
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 at an edge: load xs<=x, ys<=y, borrow<=bi, cnt<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN, on each edge:
  - diff bit = xs[0]^ys[0]^borrow.
  - borrow <= (~xs[0]&ys[0]) | (~(xs[0]^ys[0])&borrow).
  - diff bit shifts into the MSB of the result register, which shifts right.
  - xs and ys shift right.
  - cnt increments.
  - When cnt==WIDTH-1, the edge commits d<=completed result and bo<=final borrow, then moves to DONE.
  - start is ignored throughout RUN; the operand inputs are not sampled.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then unconditionally back to IDLE.
  - start in DONE is ignored; a new start must arrive in IDLE.
- Latency:
  - start accepted at edge k; busy=1 from after edge k until edge k+WIDTH.
  - done=1 in the cycle after edge k+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles.
- Hold rule: d and bo hold their last value until the next operation completes. They never show partial results.
- Arithmetic: modulo 2^WIDTH. d = (x - y - bi) mod 2^WIDTH, and bo is the unsigned borrow from the MSB.
- Boundary values:
  - x=y, bi=0 gives d=0, bo=0.
  - x=0, y=0, bi=1 gives d=all ones, bo=1.
  - x=all ones, y=0 gives d=x, bo=0.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined: adds output port ovf (1 bit). ovf is registered alongside d on the same commit edge.
  - ovf = signed overflow = borrow into MSB XOR borrow out of MSB, i.e. (x[MSB]!=y[MSB]) && (d[MSB]!=x[MSB]) when bi=0.
  - ovf resets to 0 and holds like d.
- Not defined: no ovf port and no extra logic; behaviour otherwise identical.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - the default WIDTH constant.
  - counter width, computed as clog2(WIDTH).
- Sub-module full_subtractor (inputs a, b, bin; outputs diff, bout) holds the purely combinational per-bit cell. It is instantiated once, and the borrow flop lives in the parent.

Test Plan:
- x=0010, y=0001, bi=0, start one cycle -> busy for 4 cycles, done pulse 5 cycles after start edge, d=0001, bo=0.
- x=0001, y=0010, bi=0 -> d=1111, bo=1. With SERIAL_SUBTRACTOR_OVF_EN: ovf=0.
- x=0000, y=0000, bi=1 -> d=1111, bo=1. Then x=0111, y=0111, bi=0 -> d=0000, bo=0; d holds 1111 until the second done.
- SERIAL_SUBTRACTOR_OVF_EN: x=1000, y=0001, bi=0 -> d=0111, bo=0, ovf=1. Also x=0111, y=1111 -> d=1000, bo=1, ovf=1.
- start pulsed again during RUN with different x/y -> ignored; result matches the first operands and exactly one done pulse.
- rst asserted two cycles into RUN -> busy, done, d and bo go to 0 immediately. After release, a fresh start with x=0101, y=0011 gives d=0010, bo=0.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units: state encoding,
// default operand width and the bit-counter width helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // The counter must hold WIDTH-1; it is never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor: diff = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = x - y - bi, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the registered signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for start; d/bo/ovf hold the last result
// RUN   | one difference bit per clock, WIDTH clocks
// DONE  | one-cycle done pulse, then back to IDLE
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH-1:0] rs;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             diff_bit;
    logic             bout_bit;

    full_subtractor u_cell (
        .a    (xs[0]),
        .b    (ys[0]),
        .bin  (borrow),
        .diff (diff_bit),
        .bout (bout_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            xs     <= '0;
            ys     <= '0;
            rs     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            bo     <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xs     <= x;
                        ys     <= y;
                        borrow <= bi;
                        cnt    <= '0;
                        rs     <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    xs     <= xs >> 1;
                    ys     <= ys >> 1;
                    rs     <= {diff_bit, rs[WIDTH-1:1]};
                    borrow <= bout_bit;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Outputs only change here, so partial results never show.
                        d     <= {diff_bit, rs[WIDTH-1:1]};
                        bo    <= bout_bit;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf   <= borrow ^ bout_bit;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         bi = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] hold_d   = '0;
    logic         hold_bo  = 1'b0;
    logic         hold_ovf = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .bi    (bi),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bo    (bo)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain modular arithmetic on integers.
    function automatic logic [W-1:0] ref_d(input int a, input int b, input int c);
        return W'((a - b - c) & ((1 << W) - 1));
    endfunction

    function automatic logic ref_bo(input int a, input int b, input int c);
        return (a < b + c);
    endfunction

    function automatic logic ref_ovf(input int a, input int b, input int c);
        int sa, sb, r;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        r  = sa - sb - c;
        return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    endfunction

    // poke_run: pulse start again mid-RUN with other operands.
    // poke_done: hold start high during the DONE cycle.
    task automatic run_op(input int a, input int b, input int c, input string tag,
                          input bit poke_run, input bit poke_done);
        logic [W-1:0] ed;
        logic         ebo;
        logic         eovf;
        ed   = ref_d(a, b, c);
        ebo  = ref_bo(a, b, c);
        eovf = ref_ovf(a, b, c);
        @(negedge clk);
        x = W'(a); y = W'(b); bi = c[0]; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x = W'($urandom); y = W'($urandom); bi = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check({tag, " busy"}, busy, 1);
            check({tag, " done_low"}, done, 0);
            check({tag, " d_hold"}, d, hold_d);
            check({tag, " bo_hold"}, bo, hold_bo);
            if (poke_run && i == 1) begin
                x = ~W'(a); y = W'(a); bi = ~c[0]; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, " done"}, done, 1);
        check({tag, " busy_low"}, busy, 0);
        check({tag, " d"}, d, ed);
        check({tag, " bo"}, bo, ebo);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check({tag, " ovf"}, ovf, eovf);
        hold_ovf = eovf;
`endif
        hold_d  = ed;
        hold_bo = ebo;
        if (poke_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " done_once"}, done, 0);
        check({tag, " idle_after"}, busy, 0);
    endtask

    initial begin
        #2;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset d", d, 0);
        check("reset bo", bo, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("reset ovf", ovf, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(2, 1, 0, "t2m1", 0, 0);
        run_op(1, 2, 0, "t1m2", 0, 0);
        run_op(0, 0, 1, "zero_bi", 0, 0);
        run_op(7, 7, 0, "eq", 0, 0);
        run_op(15, 0, 0, "ones", 0, 0);
        run_op(8, 1, 0, "ovf_neg", 0, 0);
        run_op(7, 15, 0, "ovf_pos", 0, 0);
        run_op(9, 4, 1, "poke_run", 1, 0);
        run_op(3, 10, 0, "poke_done", 0, 1);

        // Async reset two cycles into RUN.
        @(negedge clk);
        x = 4'd12; y = 4'd3; bi = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst busy", busy, 0);
        check("mid_rst done", done, 0);
        check("mid_rst d", d, 0);
        check("mid_rst bo", bo, 0);
        hold_d = '0; hold_bo = 1'b0; hold_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("mid_rst no_done", done, 0);
        end
        run_op(5, 3, 0, "after_rst", 0, 0);

        for (int i = 0; i < 20; i++) begin
            run_op(int'($urandom_range((1 << W) - 1)), int'($urandom_range((1 << W) - 1)),
                   int'($urandom_range(1)), "rand", 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
